// File: rtl/daten_speicher_antwort.sv
// Data-memory responder: accepts CPU read/write requests, waits WARTEZYKLEN cycles,
// then performs the access on an internal word RAM and holds the 4-phase acknowledge.
module daten_speicher_antwort #(
    parameter int WORDSIZE    = 32,
    parameter int WORDS       = 256,
    parameter int WARTEZYKLEN = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                LeseDaten,
    input  logic                SchreibeDaten,
    input  logic [31:0]         DatenAdresse,
    input  logic [WORDSIZE-1:0] DatenRaus,
    output logic [WORDSIZE-1:0] DatenRein,
    output logic                DatenGeladen,
    output logic                DatenGespeichert,
    output logic                Fehler
);
    localparam int         IW      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0] WAIT_TC = 4'(WARTEZYKLEN);

    // state  | meaning
    // BEREIT | idle, sampling requests
    // WARTEN | request latched, counting wait states
    // FERTIG | access done, acknowledge held until the request drops
    typedef enum logic [1:0] {BEREIT, WARTEN, FERTIG} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [31:0]         addr_q;
    logic [WORDSIZE-1:0] data_q;
    logic                is_write;
    logic [WORDSIZE-1:0] mem [WORDS];

    logic [IW-1:0] idx;
    logic          out_of_range;
    logic          execute;
    logic          req_held;

    assign idx          = addr_q[IW-1:0];
    assign out_of_range = (addr_q >> IW) != 32'd0;
    assign execute      = (state == WARTEN) && (cnt == WAIT_TC);
    assign req_held     = is_write ? SchreibeDaten : LeseDaten;

    // RAM is deliberately outside the reset domain so its contents survive Reset.
    always_ff @(posedge Clock) begin
        if (!Reset && execute && is_write && !out_of_range) begin
            mem[idx] <= data_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state            <= BEREIT;
            cnt              <= 4'd0;
            addr_q           <= 32'd0;
            data_q           <= '0;
            is_write         <= 1'b0;
            DatenRein        <= '0;
            DatenGeladen     <= 1'b0;
            DatenGespeichert <= 1'b0;
            Fehler           <= 1'b0;
        end else begin
            case (state)
                BEREIT: begin
                    if (SchreibeDaten) begin
                        addr_q   <= DatenAdresse;
                        data_q   <= DatenRaus;
                        is_write <= 1'b1;
                        cnt      <= 4'd0;
                        state    <= WARTEN;
                    end else if (LeseDaten) begin
                        addr_q   <= DatenAdresse;
                        is_write <= 1'b0;
                        cnt      <= 4'd0;
                        state    <= WARTEN;
                    end
                end
                WARTEN: begin
                    if (cnt == WAIT_TC) begin
                        Fehler <= out_of_range;
                        if (is_write) begin
                            DatenGespeichert <= 1'b1;
                        end else begin
                            DatenGeladen <= 1'b1;
                            DatenRein    <= out_of_range ? '0 : mem[idx];
                        end
                        state <= FERTIG;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                FERTIG: begin
                    // An early-dropped request lands here already low: one-cycle acknowledge.
                    if (!req_held) begin
                        DatenGeladen     <= 1'b0;
                        DatenGespeichert <= 1'b0;
                        Fehler           <= 1'b0;
                        state            <= BEREIT;
                    end
                end
                default: state <= BEREIT;
            endcase
        end
    end
endmodule

// File: tb/tb_daten_speicher_antwort.sv
// Bench for daten_speicher_antwort: two instances (2 and 0 wait states) checked every
// cycle against a transaction-timed expectation model with a word-array memory image.
module tb_daten_speicher_antwort;
    logic        clk;
    logic        rst    [2];
    logic        lese   [2];
    logic        schr   [2];
    logic [31:0] adr    [2];
    logic [31:0] raus   [2];
    logic [31:0] rein   [2];
    logic        gel    [2];
    logic        ges    [2];
    logic        feh    [2];

    logic [31:0] exp_rein [2];
    logic        exp_gel  [2];
    logic        exp_ges  [2];
    logic        exp_feh  [2];
    logic [31:0] mdl [2][256];
    bit          chk_on;
    int          checks;
    int          failures;

    daten_speicher_antwort #(.WORDSIZE(32), .WORDS(256), .WARTEZYKLEN(2)) dut_w2 (
        .Clock(clk), .Reset(rst[0]), .LeseDaten(lese[0]), .SchreibeDaten(schr[0]),
        .DatenAdresse(adr[0]), .DatenRaus(raus[0]), .DatenRein(rein[0]),
        .DatenGeladen(gel[0]), .DatenGespeichert(ges[0]), .Fehler(feh[0])
    );

    daten_speicher_antwort #(.WORDSIZE(32), .WORDS(256), .WARTEZYKLEN(0)) dut_w0 (
        .Clock(clk), .Reset(rst[1]), .LeseDaten(lese[1]), .SchreibeDaten(schr[1]),
        .DatenAdresse(adr[1]), .DatenRaus(raus[1]), .DatenRein(rein[1]),
        .DatenGeladen(gel[1]), .DatenGespeichert(ges[1]), .Fehler(feh[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t actual=%h required=%h", nm, i, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk("DatenRein", i, rein[i], exp_rein[i]);
                chk("DatenGeladen", i, 32'(gel[i]), 32'(exp_gel[i]));
                chk("DatenGespeichert", i, 32'(ges[i]), 32'(exp_ges[i]));
                chk("Fehler", i, 32'(feh[i]), 32'(exp_feh[i]));
            end
        end
    end

    function automatic int waits(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // One access: accepted at edge T, acknowledge expected after edge T+1+waits.
    // hold<0 drops the request right after acceptance; otherwise it is held hold
    // extra cycles after the acknowledge appears.
    task automatic acc(input int i, input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [31:0] d, input int hold);
        bit oor;
        int ix;
        oor = (addr[31:8] != 24'd0);
        ix  = int'(addr[7:0]);
        schr[i] = wr;
        lese[i] = rd;
        adr[i]  = addr;
        raus[i] = d;
        @(posedge clk); #1;
        adr[i]  = ~addr;
        raus[i] = ~d;
        if (hold < 0) begin
            schr[i] = 1'b0;
            lese[i] = 1'b0;
        end
        repeat (waits(i) + 1) @(posedge clk);
        #1;
        exp_feh[i] = oor;
        if (wr) begin
            exp_ges[i] = 1'b1;
            if (!oor) mdl[i][ix] = d;
        end else begin
            exp_gel[i]  = 1'b1;
            exp_rein[i] = oor ? 32'd0 : mdl[i][ix];
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
        end
        schr[i] = 1'b0;
        lese[i] = 1'b0;
        @(posedge clk); #1;
        exp_gel[i] = 1'b0;
        exp_ges[i] = 1'b0;
        exp_feh[i] = 1'b0;
    endtask

    // Write accepted, then Reset hits the next edge, before the write cycle.
    task automatic abort_write(input int i, input logic [31:0] addr, input logic [31:0] d);
        schr[i] = 1'b1;
        adr[i]  = addr;
        raus[i] = d;
        @(posedge clk); #1;
        rst[i]  = 1'b1;
        schr[i] = 1'b0;
        @(posedge clk); #1;
        exp_rein[i] = 32'd0;
        exp_gel[i]  = 1'b0;
        exp_ges[i]  = 1'b0;
        exp_feh[i]  = 1'b0;
        rst[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        chk_on   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; lese[i] = 1'b0; schr[i] = 1'b0;
            adr[i] = 32'd0; raus[i] = 32'd0;
            exp_rein[i] = 32'd0; exp_gel[i] = 1'b0; exp_ges[i] = 1'b0; exp_feh[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk_on = 1'b1;
        @(posedge clk); #1;

        acc(0, 1, 0, 32'd5, 32'hDEADBEEF, 1);
        acc(0, 1, 0, 32'd6, 32'h66666666, 0);
        acc(0, 1, 0, 32'd8, 32'h88888888, 0);
        acc(0, 0, 1, 32'd5, 32'h0, 2);
        chk("lit_read5", 0, rein[0], 32'hDEADBEEF);

        acc(0, 1, 0, 32'd7, 32'h12345678, 2);
        acc(0, 0, 1, 32'd7, 32'h0, 1);
        chk("lit_read7", 0, rein[0], 32'h12345678);
        acc(0, 0, 1, 32'd6, 32'h0, 0);
        chk("lit_read6", 0, rein[0], 32'h66666666);
        acc(0, 0, 1, 32'd8, 32'h0, 0);
        chk("lit_read8", 0, rein[0], 32'h88888888);

        acc(0, 1, 1, 32'd3, 32'hA5A5A5A5, 1);
        acc(0, 0, 1, 32'd3, 32'h0, 0);
        chk("lit_read3", 0, rein[0], 32'hA5A5A5A5);

        acc(0, 0, 1, 32'h00000100, 32'h0, 1);
        chk("lit_read_oor", 0, rein[0], 32'h0);
        acc(0, 1, 0, 32'h00000105, 32'hBAD0BAD0, 0);
        acc(0, 0, 1, 32'd5, 32'h0, 0);
        chk("lit_read5_after_oor_write", 0, rein[0], 32'hDEADBEEF);

        acc(0, 1, 0, 32'd9, 32'h00000099, 0);
        abort_write(0, 32'd9, 32'hFFFF0000);
        chk("lit_rein_after_reset", 0, rein[0], 32'h0);
        acc(0, 0, 1, 32'd9, 32'h0, 0);
        chk("lit_read9_after_abort", 0, rein[0], 32'h00000099);

        acc(0, 0, 1, 32'd7, 32'h0, -1);
        chk("lit_read7_early_drop", 0, rein[0], 32'h12345678);

        acc(1, 1, 0, 32'd1, 32'h11111111, 0);
        acc(1, 1, 0, 32'd2, 32'h22222222, 0);
        acc(1, 0, 1, 32'd1, 32'h0, 0);
        chk("lit_w0_read1", 1, rein[1], 32'h11111111);
        acc(1, 0, 1, 32'd2, 32'h0, 0);
        chk("lit_w0_read2", 1, rein[1], 32'h22222222);

        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
